pixel_sweep_sequencer: RTL and testbench

PIXEL_SWEEP_SEQUENCER -- requirements
Module: pixel_sweep_sequencer

---
 rtl/pixel_sweep_sequencer_if.sv | 28 ++
 rtl/pixel_sweep_sequencer.sv | 96 +++++++++
 tb/tb_pixel_sweep_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pixel_sweep_sequencer_if.sv
// Control bundle between the pixel sweep sequencer and the dithering datapath / MCU link.
interface pixel_sweep_sequencer_if #(
  parameter int IMAGE_ADDR_WIDTH = 12
);
  logic                        MCU_TX_RDY;
  logic                        rden_a;
  logic                        rden_b;
  logic                        wren_a;
  logic                        wren_b;
  logic                        store_old_p;
  logic                        compare_and_store_n;
  logic [3:0]                  compute_fin;
  logic [IMAGE_ADDR_WIDTH-1:0] png_idx;
  logic                        MCU_RX_RDY;
  logic                        busy;

  modport master (
    input  MCU_TX_RDY,
    output rden_a, rden_b, wren_a, wren_b, store_old_p, compare_and_store_n,
    output compute_fin, png_idx, MCU_RX_RDY, busy
  );

  modport slave (
    output MCU_TX_RDY,
    input  rden_a, rden_b, wren_a, wren_b, store_old_p, compare_and_store_n,
    input  compute_fin, png_idx, MCU_RX_RDY, busy
  );
endinterface

// File: rtl/pixel_sweep_sequencer.sv
// Frame sequencer: loads a frame byte-by-byte from the MCU, then sweeps every pixel
// through a fixed 6-cycle read-old / quantize / diffuse-error schedule, then
// holds the finished frame until the MCU acknowledges it.
module pixel_sweep_sequencer #(
  parameter int IMAGEX           = 64,
  parameter int IMAGEY           = 64,
  parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE)
) (
  input logic                    clk,
  input logic                    rst,
  pixel_sweep_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    LOAD, RD_OLD, QUANT, RD_E_SW, WR_E_SW, RD_S_SE, WR_S_SE, DONE
  } state_t;

  localparam logic [IMAGE_ADDR_WIDTH-1:0] LAST_IDX = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);

  state_t                      state;
  logic [IMAGE_ADDR_WIDTH-1:0] idx;

  // State and pixel index; strobes only matter in LOAD (data) and DONE (acknowledge).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      idx   <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.MCU_TX_RDY) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= RD_OLD;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        RD_OLD:  state <= QUANT;
        QUANT:   state <= RD_E_SW;
        RD_E_SW: state <= WR_E_SW;
        WR_E_SW: state <= RD_S_SE;
        RD_S_SE: state <= WR_S_SE;
        WR_S_SE: begin
          // Border neighbours are masked by the datapath, so every pixel takes all six steps.
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= RD_OLD;
          end
        end
        DONE: begin
          if (bus.MCU_TX_RDY) begin
            idx   <= '0;
            state <= LOAD;
          end
        end
        default: begin
          idx   <= '0;
          state <= LOAD;
        end
      endcase
    end
  end

  // Moore decode of the control strobes; only the LOAD write follows the input strobe,
  // and it is gated by rst so reset silences every enable immediately.
  always_comb begin
    bus.rden_a              = 1'b0;
    bus.rden_b              = 1'b0;
    bus.wren_a              = 1'b0;
    bus.wren_b              = 1'b0;
    bus.store_old_p         = 1'b0;
    bus.compare_and_store_n = 1'b0;
    bus.compute_fin         = 4'b0000;
    bus.MCU_RX_RDY          = 1'b0;
    bus.busy                = 1'b0;
    bus.png_idx             = idx;
    case (state)
      LOAD:    bus.wren_a = bus.MCU_TX_RDY & ~rst;
      RD_OLD:  begin bus.busy = 1'b1; bus.rden_a = 1'b1; bus.store_old_p = 1'b1; end
      QUANT:   begin bus.busy = 1'b1; bus.wren_a = 1'b1; bus.compare_and_store_n = 1'b1; end
      RD_E_SW: begin bus.busy = 1'b1; bus.rden_a = 1'b1; bus.rden_b = 1'b1; bus.compute_fin = 4'b0001; end
      WR_E_SW: begin bus.busy = 1'b1; bus.wren_a = 1'b1; bus.wren_b = 1'b1; bus.compute_fin = 4'b0010; end
      RD_S_SE: begin bus.busy = 1'b1; bus.rden_a = 1'b1; bus.rden_b = 1'b1; bus.compute_fin = 4'b0100; end
      WR_S_SE: begin bus.busy = 1'b1; bus.wren_a = 1'b1; bus.wren_b = 1'b1; bus.compute_fin = 4'b1000; end
      DONE:    bus.MCU_RX_RDY = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pixel_sweep_sequencer.sv
// Bench for the pixel sweep sequencer on a 4x4 frame: a cycle-counting model is
// compared against the DUT every cycle, plus literal checks of key points.
module tb_pixel_sweep_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pixel_sweep_sequencer_if #(.IMAGE_ADDR_WIDTH(4)) bus();
  pixel_sweep_sequencer #(.IMAGEX(4), .IMAGEY(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Model: mode 0 = loading (m_idx pixels stored), 1 = dithering (m_d cycles elapsed), 2 = done.
  int m_mode = 0;
  int m_idx  = 0;
  int m_d    = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0; m_idx <= 0; m_d <= 0;
    end else begin
      case (m_mode)
        0: if (bus.MCU_TX_RDY) begin
             if (m_idx == 15) begin m_mode <= 1; m_d <= 0; m_idx <= 0; end
             else m_idx <= m_idx + 1;
           end
        1: if (m_d == 16 * 6 - 1) m_mode <= 2; else m_d <= m_d + 1;
        default: if (bus.MCU_TX_RDY) begin m_mode <= 0; m_idx <= 0; end
      endcase
    end
  end

  // Expected output vector from the model, compared against the DUT every cycle.
  always @(negedge clk) begin
    logic ra, rb, wa, wb, so, cs, rx, bz;
    logic [3:0] cf, pi;
    int step;
    ra = 0; rb = 0; wa = 0; wb = 0; so = 0; cs = 0; rx = 0; bz = 0; cf = 0; pi = 0;
    step = m_d % 6;
    case (m_mode)
      0: begin wa = bus.MCU_TX_RDY & ~rst; pi = 4'(m_idx); end
      1: begin
           bz = 1; pi = 4'(m_d / 6);
           ra = (step % 2 == 0); wa = (step % 2 == 1);
           rb = (step == 2 || step == 4); wb = (step == 3 || step == 5);
           so = (step == 0); cs = (step == 1);
           cf = (step >= 2) ? 4'(1 << (step - 2)) : 4'b0000;
         end
      default: rx = 1;
    endcase
    chk("cycle_outputs",
        {16'h0, bus.rden_a, bus.rden_b, bus.wren_a, bus.wren_b, bus.store_old_p,
         bus.compare_and_store_n, bus.compute_fin, bus.png_idx, bus.MCU_RX_RDY, bus.busy},
        {16'h0, ra, rb, wa, wb, so, cs, cf, pi, rx, bz});
  end

  logic [3:0] cf_log  [0:96];
  logic [3:0] idx_log [0:96];
  logic       so_log  [0:96];
  logic       cs_log  [0:96];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_frame();
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      chk("load_idx", 32'(bus.png_idx), 32'(i));
      bus.MCU_TX_RDY = 1'b1;
      #1;
      chk("load_wren", 32'(bus.wren_a), 32'd1);
      tick();
      bus.MCU_TX_RDY = 1'b0;
    end
    chk("rd_old_entry", {29'h0, bus.store_old_p, bus.busy, bus.rden_a}, 32'h7);
    chk("rd_old_idx", 32'(bus.png_idx), 32'd0);
  endtask

  // Called right after the edge that took the last load strobe.
  task automatic wait_done(input bit inject);
    int n;
    n = 0;
    forever begin
      if (n <= 96) begin
        cf_log[n] = bus.compute_fin; idx_log[n] = bus.png_idx;
        so_log[n] = bus.store_old_p; cs_log[n] = bus.compare_and_store_n;
      end
      if (bus.MCU_RX_RDY || n >= 200) break;
      if (inject && n < 95 && (n % 7 == 3)) bus.MCU_TX_RDY = 1'b1;
      tick();
      bus.MCU_TX_RDY = 1'b0;
      n++;
    end
    chk("done_latency", 32'(n), 32'd96);
    chk("done_idx", 32'(bus.png_idx), 32'd0);
    chk("done_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.MCU_TX_RDY = 1'b0;
    #1;
    chk("reset_outputs", {bus.wren_a, bus.rden_a, bus.compute_fin, bus.png_idx, bus.MCU_RX_RDY, bus.busy}, 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Frame 1: plain load and sweep, pixel 5 traced.
    load_frame();
    wait_done(1'b0);
    chk("px5_fin0", 32'(cf_log[30]), 32'h0);
    chk("px5_fin1", 32'(cf_log[31]), 32'h0);
    chk("px5_fin2", 32'(cf_log[32]), 32'h1);
    chk("px5_fin3", 32'(cf_log[33]), 32'h2);
    chk("px5_fin4", 32'(cf_log[34]), 32'h4);
    chk("px5_fin5", 32'(cf_log[35]), 32'h8);
    chk("px5_store_old", 32'(so_log[30]), 32'd1);
    chk("px5_quant", 32'(cs_log[31]), 32'd1);
    chk("px5_idx", 32'(idx_log[35]), 32'd5);
    chk("px6_idx", 32'(idx_log[36]), 32'd6);

    // Hold in DONE, then acknowledge.
    repeat (3) tick();
    chk("done_hold", 32'(bus.MCU_RX_RDY), 32'd1);
    bus.MCU_TX_RDY = 1'b1;
    #1;
    chk("ack_no_write", 32'(bus.wren_a), 32'd0);
    tick();
    bus.MCU_TX_RDY = 1'b0;
    chk("ack_rx_low", 32'(bus.MCU_RX_RDY), 32'd0);
    chk("ack_idx", 32'(bus.png_idx), 32'd0);

    // Frame 2: stray strobes during the sweep must be ignored.
    load_frame();
    wait_done(1'b1);
    bus.MCU_TX_RDY = 1'b1;
    tick();
    bus.MCU_TX_RDY = 1'b0;

    // Frame 3: reset while pixel 9 is in its first write-back step.
    load_frame();
    repeat (9 * 6 + 3) tick();
    chk("pre_rst_fin", 32'(bus.compute_fin), 32'h2);
    chk("pre_rst_idx", 32'(bus.png_idx), 32'd9);
    #2 rst = 1'b1;
    #1;
    chk("rst_outputs",
        {bus.rden_a, bus.rden_b, bus.wren_a, bus.wren_b, bus.store_old_p,
         bus.compare_and_store_n, bus.compute_fin, bus.png_idx, bus.MCU_RX_RDY, bus.busy}, 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    load_frame();
    wait_done(1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
